// File: rtl/dmem_access_unit.sv
// Load/store unit: runs one data-memory transaction per accepted request over a
// req/ack handshake, with byte-lane steering, load extension and error reporting.
module dmem_access_unit #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    input  logic        is_store,
    input  logic [1:0]  size,
    input  logic        load_unsigned,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic        err_align,
    output logic        err_timeout,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    localparam int unsigned CNT_W = 8;
    localparam int unsigned DW    = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n, cnt_inc_c;
    logic               req_store, req_store_n;
    logic [1:0]         req_size, req_size_n;
    logic               req_unsigned, req_unsigned_n;
    logic [1:0]         req_lane, req_lane_n;

    logic               busy_n, done_n, err_align_n, err_timeout_n;
    logic               mem_req_n, mem_we_n;
    logic [DW-1:0]      rdata_n, mem_addr_n, mem_wdata_n;
    logic [3:0]         mem_be_n;

    logic               misaligned_c;
    logic [3:0]         be_c;
    logic [DW-1:0]      store_data_c;
    logic [7:0]         load_byte_c;
    logic [15:0]        load_half_c;
    logic [DW-1:0]      load_data_c;

    // Request decode from the live inputs, used only in the acceptance cycle.
    always_comb begin
        misaligned_c = 1'b0;
        be_c         = 4'b0000;
        store_data_c = wdata;
        case (size)
            2'b00: begin
                be_c         = 4'b0001 << addr[1:0];
                store_data_c = {4{wdata[7:0]}};
            end
            2'b01: begin
                misaligned_c = addr[0];
                be_c         = 4'b0011 << {addr[1], 1'b0};
                store_data_c = {2{wdata[15:0]}};
            end
            2'b10: begin
                misaligned_c = (addr[1:0] != 2'b00);
                be_c         = 4'b1111;
            end
            default: misaligned_c = 1'b1;
        endcase
    end

    // Load-data lane select and extension from the latched request.
    always_comb begin
        case (req_lane)
            2'd0:    load_byte_c = mem_rdata[7:0];
            2'd1:    load_byte_c = mem_rdata[15:8];
            2'd2:    load_byte_c = mem_rdata[23:16];
            default: load_byte_c = mem_rdata[31:24];
        endcase
        load_half_c = req_lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (req_size)
            2'b00:   load_data_c = {{24{~req_unsigned & load_byte_c[7]}}, load_byte_c};
            2'b01:   load_data_c = {{16{~req_unsigned & load_half_c[15]}}, load_half_c};
            default: load_data_c = mem_rdata;
        endcase
    end

    assign cnt_inc_c = cnt + CNT_W'(1);

    // Next-state and next-output logic.
    always_comb begin
        state_n        = state;
        cnt_n          = cnt;
        req_store_n    = req_store;
        req_size_n     = req_size;
        req_unsigned_n = req_unsigned;
        req_lane_n     = req_lane;
        busy_n         = busy;
        done_n         = 1'b0;
        rdata_n        = rdata;
        err_align_n    = err_align;
        err_timeout_n  = err_timeout;
        mem_req_n      = mem_req;
        mem_we_n       = mem_we;
        mem_addr_n     = mem_addr;
        mem_be_n       = mem_be;
        mem_wdata_n    = mem_wdata;

        case (state)
            IDLE: begin
                if (start) begin
                    req_store_n    = is_store;
                    req_size_n     = size;
                    req_unsigned_n = load_unsigned;
                    req_lane_n     = addr[1:0];
                    err_align_n    = 1'b0;
                    err_timeout_n  = 1'b0;
                    busy_n         = 1'b1;
                    if (misaligned_c) begin
                        state_n     = FINISH;
                        done_n      = 1'b1;
                        err_align_n = 1'b1;
                    end else begin
                        state_n     = ACCESS;
                        cnt_n       = '0;
                        mem_req_n   = 1'b1;
                        mem_we_n    = is_store;
                        mem_addr_n  = {addr[31:2], 2'b00};
                        mem_be_n    = be_c;
                        mem_wdata_n = store_data_c;
                    end
                end
            end
            ACCESS: begin
                // An ack in the final counted cycle takes priority over the timeout.
                if (mem_ack || (cnt_inc_c == CNT_W'(TIMEOUT))) begin
                    state_n     = FINISH;
                    done_n      = 1'b1;
                    mem_req_n   = 1'b0;
                    mem_we_n    = 1'b0;
                    mem_addr_n  = '0;
                    mem_be_n    = 4'b0000;
                    mem_wdata_n = '0;
                    if (mem_ack) begin
                        if (!req_store) begin
                            rdata_n = load_data_c;
                        end
                    end else begin
                        err_timeout_n = 1'b1;
                        cnt_n         = cnt_inc_c;
                    end
                end else begin
                    cnt_n = cnt_inc_c;
                end
            end
            FINISH: begin
                state_n = IDLE;
                busy_n  = 1'b0;
            end
            default: begin
                state_n = IDLE;
                busy_n  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state        <= IDLE;
            cnt          <= '0;
            req_store    <= 1'b0;
            req_size     <= 2'b00;
            req_unsigned <= 1'b0;
            req_lane     <= 2'b00;
            busy         <= 1'b0;
            done         <= 1'b0;
            rdata        <= '0;
            err_align    <= 1'b0;
            err_timeout  <= 1'b0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_be       <= 4'b0000;
            mem_wdata    <= '0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            req_store    <= req_store_n;
            req_size     <= req_size_n;
            req_unsigned <= req_unsigned_n;
            req_lane     <= req_lane_n;
            busy         <= busy_n;
            done         <= done_n;
            rdata        <= rdata_n;
            err_align    <= err_align_n;
            err_timeout  <= err_timeout_n;
            mem_req      <= mem_req_n;
            mem_we       <= mem_we_n;
            mem_addr     <= mem_addr_n;
            mem_be       <= mem_be_n;
            mem_wdata    <= mem_wdata_n;
        end
    end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Directed self-checking bench for dmem_access_unit with hand-computed expectations.
module tb_dmem_access_unit;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start;
    logic        is_store;
    logic [1:0]  size;
    logic        load_unsigned;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] rdata;
    logic        err_align;
    logic        err_timeout;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    int checks = 0;
    int errors = 0;

    dmem_access_unit #(.TIMEOUT(15)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .start         (start),
        .is_store      (is_store),
        .size          (size),
        .load_unsigned (load_unsigned),
        .addr          (addr),
        .wdata         (wdata),
        .busy          (busy),
        .done          (done),
        .rdata         (rdata),
        .err_align     (err_align),
        .err_timeout   (err_timeout),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_be        (mem_be),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata),
        .mem_ack       (mem_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request for one cycle; returns in the first cycle after acceptance.
    task automatic issue(input logic st, input logic [1:0] sz, input logic lu,
                         input logic [31:0] a, input logic [31:0] wd);
        is_store      = st;
        size          = sz;
        load_unsigned = lu;
        addr          = a;
        wdata         = wd;
        start         = 1'b1;
        tick();
        start = 1'b0;
    endtask

    int n_req;

    initial begin
        rstn = 1'b0; start = 1'b0; is_store = 1'b0; size = 2'b00; load_unsigned = 1'b0;
        addr = '0; wdata = '0; mem_rdata = '0; mem_ack = 1'b0;
        tick();
        tick();
        rstn = 1'b1;

        // Reset state
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_errs", {30'd0, err_align, err_timeout}, 32'd0);
        check("rst_mem_ctl", {29'd0, mem_req, mem_we, 1'b0}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_be", 32'(mem_be), 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'h0);

        // Signed byte load, lane 3, ack in the first ACCESS cycle
        issue(1'b0, 2'b00, 1'b0, 32'h0000_1003, 32'h0);
        check("lb_req", 32'(mem_req), 32'd1);
        check("lb_we", 32'(mem_we), 32'd0);
        check("lb_addr", mem_addr, 32'h0000_1000);
        check("lb_be", 32'(mem_be), 32'b1000);
        check("lb_busy_done", {30'd0, busy, done}, 32'b10);
        mem_rdata = 32'h80FF_1234;
        mem_ack   = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("lb_done", 32'(done), 32'd1);
        check("lb_rdata", rdata, 32'hFFFF_FF80);
        check("lb_errs", {30'd0, err_align, err_timeout}, 32'd0);
        check("lb_req_drop", 32'(mem_req), 32'd0);
        tick();
        check("lb_idle", {30'd0, busy, done}, 32'd0);

        // Halfword store with ack delayed three cycles
        issue(1'b1, 2'b01, 1'b0, 32'h0000_2002, 32'hDEAD_BEEF);
        for (int i = 0; i < 4; i++) begin
            check("sh_req", 32'(mem_req), 32'd1);
            check("sh_we", 32'(mem_we), 32'd1);
            check("sh_addr", mem_addr, 32'h0000_2000);
            check("sh_be", 32'(mem_be), 32'b1100);
            check("sh_wdata", mem_wdata, 32'hBEEF_BEEF);
            check("sh_nodone", 32'(done), 32'd0);
            if (i < 3) tick();
        end
        mem_rdata = 32'h1234_5678;
        mem_ack   = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("sh_done", 32'(done), 32'd1);
        check("sh_rdata_kept", rdata, 32'hFFFF_FF80);
        check("sh_be_off", 32'(mem_be), 32'd0);
        tick();

        // Misaligned word, then illegal size
        issue(1'b0, 2'b10, 1'b0, 32'h0000_0006, 32'h0);
        check("mw_done", 32'(done), 32'd1);
        check("mw_err", {30'd0, err_align, err_timeout}, 32'b10);
        check("mw_noreq", 32'(mem_req), 32'd0);
        tick();
        check("mw_idle", {30'd0, busy, done}, 32'd0);
        check("mw_err_hold", 32'(err_align), 32'd1);
        check("mw_noreq2", 32'(mem_req), 32'd0);
        issue(1'b0, 2'b11, 1'b0, 32'h0000_0000, 32'h0);
        check("il_done", 32'(done), 32'd1);
        check("il_err", 32'(err_align), 32'd1);
        check("il_noreq", 32'(mem_req), 32'd0);
        check("il_rdata_kept", rdata, 32'hFFFF_FF80);
        tick();

        // Timeout: no ack ever
        issue(1'b0, 2'b10, 1'b0, 32'h0000_0040, 32'h0);
        check("to_err_clr", 32'(err_align), 32'd0);
        n_req = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            if (mem_req) n_req++;
            tick();
        end
        check("to_done", 32'(done), 32'd1);
        check("to_req_cycles", 32'(n_req), 32'd15);
        check("to_err", {30'd0, err_align, err_timeout}, 32'b01);
        check("to_rdata_kept", rdata, 32'hFFFF_FF80);
        tick();

        // Ack on the 15th ACCESS cycle wins over the timeout
        issue(1'b0, 2'b10, 1'b0, 32'h0000_0044, 32'h0);
        check("t15_err_clr", 32'(err_timeout), 32'd0);
        for (int i = 0; i < 14; i++) tick();
        check("t15_req", 32'(mem_req), 32'd1);
        mem_rdata = 32'hCAFE_F00D;
        mem_ack   = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("t15_done", 32'(done), 32'd1);
        check("t15_err", {30'd0, err_align, err_timeout}, 32'd0);
        check("t15_rdata", rdata, 32'hCAFE_F00D);
        tick();

        // start while busy is ignored; unsigned upper halfword load
        issue(1'b0, 2'b01, 1'b1, 32'h0000_3002, 32'h0);
        is_store = 1'b1; size = 2'b10; addr = 32'h0000_5000; start = 1'b1;
        tick();
        start = 1'b0;
        check("bz_addr", mem_addr, 32'h0000_3000);
        check("bz_be", 32'(mem_be), 32'b1100);
        check("bz_we", 32'(mem_we), 32'd0);
        mem_rdata = 32'h8001_0000;
        mem_ack   = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("bz_done", 32'(done), 32'd1);
        check("bz_rdata", rdata, 32'h0000_8001);
        tick();
        check("bz_idle", 32'(busy), 32'd0);

        // Reset during ACCESS aborts with no done
        issue(1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0);
        check("rm_req", 32'(mem_req), 32'd1);
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        check("rm_req_off", 32'(mem_req), 32'd0);
        check("rm_ctl", {30'd0, busy, done}, 32'd0);
        check("rm_rdata", rdata, 32'h0);
        check("rm_be", 32'(mem_be), 32'd0);
        tick();
        check("rm_nodone", {30'd0, busy, done}, 32'd0);

        // New unsigned byte load after the abort
        issue(1'b0, 2'b00, 1'b1, 32'h0000_0101, 32'h0);
        check("nb_be", 32'(mem_be), 32'b0010);
        mem_rdata = 32'h0000_AB00;
        mem_ack   = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("nb_done", 32'(done), 32'd1);
        check("nb_rdata", rdata, 32'h0000_00AB);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
